huffman_tree_builder: RTL and testbench

// - Builds canonical DEFLATE Huffman codes (RFC1951 3.2.2) from a list of per-symbol code lengths in an external buffer RAM.
// - Writes one {code,len} entry per symbol into an external code table RAM, which huffman_decoder then reads.
// - Sits between the code-length buffer and the decode path; one tree is built per inc pulse.

---
 rtl/huffman_tree_builder.sv | 132 +++++++++++++
 tb/tb_huffman_tree_builder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/huffman_tree_builder.sv
// Canonical DEFLATE Huffman code builder: counts code lengths from the buffer RAM,
// derives first codes per length, then writes one {code,len} entry per symbol.
module huffman_tree_builder #(
   parameter int HUFF_CODE_LEN = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     inc,
   input  logic [5:0]               tree_num,
   input  logic [5:0]               buff_addr_bias,
   output logic [8:0]               buff_addr,
   input  logic [4:0]               buff_data,
   output logic [HUFF_CODE_LEN-1:0] huff_addr,
   output logic [4:0]               huff_code,
   output logic [3:0]               huff_len,
   output logic                     winc,
   output logic                     finish
);

   typedef enum logic [2:0] {IDLE, COUNT, CALC, ASSIGN, DONE} state_t;

   state_t      state;
   logic [5:0]  n_q;
   logic [5:0]  bias_q;
   logic [5:0]  idx;
   logic [2:0]  len_q;
   logic        len_v;
   logic [4:0]  bl_count [0:7];
   logic [4:0]  next_code [0:7];
   logic [2:0]  len_in;
   logic        rd_en;
   logic [4:0]  c2, c3, c4, c5;

   // Out-of-range lengths are folded to "unused" before anything else sees them.
   assign len_in = (buff_data > 5'd5) ? 3'd0 : buff_data[2:0];

   assign rd_en     = ((state == COUNT) || (state == ASSIGN)) && (idx < n_q);
   assign buff_addr = rd_en ? ({3'b000, bias_q} + {3'b000, idx}) : 9'd0;

   // First code of each length; next_code[1] is always 0, arithmetic wraps at 5 bits.
   assign c2 = bl_count[1] << 1;
   assign c3 = (c2 + bl_count[2]) << 1;
   assign c4 = (c3 + bl_count[3]) << 1;
   assign c5 = (c4 + bl_count[4]) << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_q       <= '0;
         bias_q    <= '0;
         idx       <= '0;
         len_q     <= '0;
         len_v     <= 1'b0;
         huff_addr <= '0;
         huff_code <= '0;
         huff_len  <= '0;
         winc      <= 1'b0;
         finish    <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            bl_count[k]  <= '0;
            next_code[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               winc   <= 1'b0;
               finish <= 1'b0;
               if (inc) begin
                  n_q    <= tree_num;
                  bias_q <= buff_addr_bias;
                  idx    <= '0;
                  len_v  <= 1'b0;
                  if (tree_num == 6'd0) begin
                     state  <= DONE;
                     finish <= 1'b1;
                  end else begin
                     state <= COUNT;
                  end
               end
            end
            COUNT: begin
               // Lengths are staged one cycle, so the last one lands in the extra cycle.
               if (len_v && (len_q != 3'd0))
                  bl_count[len_q] <= bl_count[len_q] + 5'd1;
               if (idx < n_q) begin
                  len_q <= len_in;
                  len_v <= 1'b1;
                  idx   <= idx + 6'd1;
               end else begin
                  len_v <= 1'b0;
                  state <= CALC;
               end
            end
            CALC: begin
               next_code[1] <= 5'd0;
               next_code[2] <= c2;
               next_code[3] <= c3;
               next_code[4] <= c4;
               next_code[5] <= c5;
               idx          <= '0;
               state        <= ASSIGN;
            end
            ASSIGN: begin
               if (idx < n_q) begin
                  winc      <= 1'b1;
                  huff_addr <= HUFF_CODE_LEN'(idx);
                  huff_len  <= {1'b0, len_in};
                  huff_code <= (len_in != 3'd0) ? next_code[len_in] : 5'd0;
                  if (len_in != 3'd0)
                     next_code[len_in] <= next_code[len_in] + 5'd1;
                  idx <= idx + 6'd1;
               end else begin
                  winc      <= 1'b0;
                  huff_addr <= '0;
                  huff_code <= '0;
                  huff_len  <= '0;
                  finish    <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               finish <= 1'b0;
               for (int k = 0; k < 8; k++)
                  bl_count[k] <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_tree_builder.sv
// Bench for huffman_tree_builder: buffer RAM model, RFC1951-style reference codes,
// directed spec cases plus randomized length lists.
module tb_huffman_tree_builder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inc = 1'b0;
   logic [5:0]  tree_num = '0;
   logic [5:0]  buff_addr_bias = '0;
   logic [8:0]  buff_addr;
   logic [4:0]  buff_data;
   logic [7:0]  huff_addr;
   logic [4:0]  huff_code;
   logic [3:0]  huff_len;
   logic        winc;
   logic        finish;

   logic [4:0]  mem [0:511];
   logic [16:0] exp_q[$];
   int          lens [0:63];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // Buffer RAM: data for the presented address is ready by the next clock edge.
   assign buff_data = mem[buff_addr];

   huffman_tree_builder #(.HUFF_CODE_LEN(8)) dut (
      .clk(clk), .rst_n(rst_n), .inc(inc), .tree_num(tree_num),
      .buff_addr_bias(buff_addr_bias), .buff_addr(buff_addr), .buff_data(buff_data),
      .huff_addr(huff_addr), .huff_code(huff_code), .huff_len(huff_len),
      .winc(winc), .finish(finish)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int san(input int l);
      return (l > 5) ? 0 : l;
   endfunction

   task automatic load(input int n, input int bias);
      for (int i = 0; i < n; i++) mem[bias + i] = lens[i][4:0];
   endtask

   // Reference: RFC1951 canonical code assignment, reduced mod 32.
   task automatic model(input int n);
      int bl [0:5];
      int nc [0:5];
      int code;
      int l;
      exp_q.delete();
      for (int b = 0; b <= 5; b++) begin bl[b] = 0; nc[b] = 0; end
      for (int i = 0; i < n; i++) begin
         l = san(lens[i]);
         if (l > 0) bl[l]++;
      end
      code = 0;
      for (int b = 1; b <= 5; b++) begin
         code = (code + bl[b-1]) * 2;
         nc[b] = code % 32;
      end
      for (int i = 0; i < n; i++) begin
         l = san(lens[i]);
         exp_q.push_back({8'(i), (l != 0) ? 5'(nc[l]) : 5'd0, 4'(l)});
         if (l != 0) nc[l] = (nc[l] + 1) % 32;
      end
   endtask

   // One build; cycle c is the c-th clock period after the edge that samples inc.
   task automatic run_build(input int n, input int bias, input int tail, input int repulse_at);
      int exp_fin, k, wcount, fcount;
      logic [16:0] e;
      load(n, bias);
      model(n);
      exp_fin = (n == 0) ? 1 : 2 * n + 4;
      @(negedge clk);
      inc = 1'b1; tree_num = 6'(n); buff_addr_bias = 6'(bias);
      @(posedge clk);
      k = 0; wcount = 0; fcount = 0;
      for (int c = 1; c <= exp_fin + tail; c++) begin
         @(negedge clk);
         if (c == 1) begin
            inc = 1'b0; tree_num = 6'($urandom); buff_addr_bias = 6'($urandom);
         end
         if (c == repulse_at) begin inc = 1'b1; tree_num = 6'd63; end
         if (c == repulse_at + 1) inc = 1'b0;
         if (n > 0 && c <= n)
            check("count_addr", 32'(buff_addr), 32'(bias + c - 1));
         else if (n > 0 && c >= n + 3 && c <= 2 * n + 2)
            check("assign_addr", 32'(buff_addr), 32'(bias + c - n - 3));
         else if (c > exp_fin)
            check("idle_addr", 32'(buff_addr), 32'd0);
         if (winc) begin
            wcount++;
            if (exp_q.size() == 0) check("extra_winc", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               check("entry", 32'({huff_addr, huff_code, huff_len}), 32'(e));
               check("winc_cycle", 32'(c), 32'(n + 4 + k));
               k++;
            end
         end
         if (finish) begin
            fcount++;
            check("finish_cycle", 32'(c), 32'(exp_fin));
         end
      end
      check("winc_count", 32'(wcount), 32'(n));
      check("finish_count", 32'(fcount), 32'd1);
   endtask

   task automatic set_lens(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
      lens[0] = v0; lens[1] = v1; lens[2] = v2; lens[3] = v3; lens[4] = v4;
      lens[5] = v5; lens[6] = v6; lens[7] = v7; lens[8] = v8; lens[9] = v9;
   endtask

   initial begin
      int n, bias;
      for (int i = 0; i < 512; i++) mem[i] = '0;
      for (int i = 0; i < 64; i++) lens[i] = 0;

      // Clock/reset
      repeat (3) @(negedge clk);
      check("rst_winc", 32'(winc), 32'd0);
      check("rst_finish", 32'(finish), 32'd0);
      check("rst_addr", 32'(buff_addr), 32'd0);
      check("rst_entry", 32'({huff_addr, huff_code, huff_len}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      set_lens(3, 3, 3, 4, 3, 2, 0, 4, 0, 3);
      run_build(10, 0, 1, -1);
      run_build(10, 20, 1, -1);

      lens[0] = 1;
      run_build(1, 0, 1, -1);
      run_build(0, 0, 2, -1);

      lens[0] = 2; lens[1] = 2; lens[2] = 2; lens[3] = 2;
      run_build(4, 0, 0, -1);
      lens[0] = 1; lens[1] = 1;
      run_build(2, 0, 1, -1);

      set_lens(3, 3, 3, 4, 3, 2, 0, 4, 0, 3);
      run_build(10, 0, 1, 16);

      // Abort mid-COUNT
      for (int i = 0; i < 10; i++) lens[i] = int'($urandom_range(1, 5));
      load(10, 7);
      @(negedge clk);
      inc = 1'b1; tree_num = 6'd10; buff_addr_bias = 6'd7;
      @(posedge clk);
      @(negedge clk); inc = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_winc", 32'(winc), 32'd0);
      check("abort_finish", 32'(finish), 32'd0);
      check("abort_addr", 32'(buff_addr), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         check("abort_quiet", 32'({winc, finish}), 32'd0);
      end
      run_build(10, 7, 1, -1);

      // Randomized length lists, including out-of-range values
      repeat (6) begin
         n = int'($urandom_range(1, 63));
         bias = int'($urandom_range(0, 63));
         for (int i = 0; i < n; i++)
            lens[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                  : int'($urandom_range(0, 5));
         run_build(n, bias, 1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
